csr_trap_unit: RTL and testbench

- Machine-mode CSR file and trap responder for the NPC core.
- Consumes the exception report (valid/code/pc/val) from the exception handler.
- Commits mepc/mcause/mtval/mstatus and supplies the trap_vector the handler redirects to.
- Serves Zicsr read/modify/write from the pipeline and executes mret, returning the resume PC.

---
 rtl/csr_trap_unit.sv | 145 ++++++++++++++
 tb/tb_csr_trap_unit.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap responder: commits trap state on exceptions,
// serves Zicsr read/modify/write accesses and executes mret.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h8000_0000,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exception_valid,
  input  logic [3:0]  exception_code,
  input  logic [31:0] exception_pc,
  input  logic [31:0] exception_val,
  output logic [31:0] trap_vector,
  output logic        trap_taken,
  input  logic        csr_en,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        csr_illegal,
  input  logic        mret_valid,
  output logic        mret_redirect,
  output logic [31:0] mret_pc
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MISA     = 12'h301;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MTVAL    = 12'h343;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFC;

  typedef enum logic {IDLE, TRAP_ACK} state_t;

  state_t      state_q, state_d;
  logic        mie_q, mpie_q;
  logic [31:0] mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic        csr_mapped;
  logic [31:0] csr_wval;
  logic        take_trap, take_mret, do_csr_wr;

  function automatic logic [31:0] csr_modify(input logic [1:0]  op,
                                             input logic [31:0] old,
                                             input logic [31:0] wdata);
    case (op)
      2'b01:   return wdata;
      2'b10:   return old | wdata;
      2'b11:   return old & ~wdata;
      default: return old;
    endcase
  endfunction

  assign trap_vector = mtvec_q;

  always_comb begin
    csr_mapped = 1'b1;
    csr_rdata  = 32'h0;
    case (csr_addr)
      ADDR_MSTATUS:  csr_rdata = {19'h0, 2'b11, 3'b000, mpie_q, 3'b000, mie_q, 3'b000};
      ADDR_MISA:     csr_rdata = MISA_VAL;
      ADDR_MTVEC:    csr_rdata = mtvec_q;
      ADDR_MSCRATCH: csr_rdata = mscratch_q;
      ADDR_MEPC:     csr_rdata = mepc_q;
      ADDR_MCAUSE:   csr_rdata = mcause_q;
      ADDR_MTVAL:    csr_rdata = mtval_q;
      ADDR_MHARTID:  csr_rdata = 32'h0;
      default:       csr_mapped = 1'b0;
    endcase
  end

  // Every non-zero op counts as a write, so a read-only address rejects RS/RC too.
  assign csr_illegal = csr_en && (csr_op != 2'b00) &&
                       (!csr_mapped || (csr_addr[11:10] == 2'b11));
  assign csr_wval    = csr_modify(csr_op, csr_rdata, csr_wdata);

  // Priority: exception > mret > CSR write; TRAP_ACK swallows all three.
  always_comb begin
    state_d   = state_q;
    take_trap = 1'b0;
    take_mret = 1'b0;
    do_csr_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (exception_valid) begin
          take_trap = 1'b1;
          state_d   = TRAP_ACK;
        end else if (mret_valid) begin
          take_mret = 1'b1;
        end else if (csr_en && (csr_op != 2'b00) && !csr_illegal) begin
          do_csr_wr = 1'b1;
        end
      end
      TRAP_ACK: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= MTVEC_RESET & ALIGN_MASK;
      mscratch_q    <= 32'h0;
      mepc_q        <= 32'h0;
      mcause_q      <= 32'h0;
      mtval_q       <= 32'h0;
      trap_taken    <= 1'b0;
      mret_redirect <= 1'b0;
      mret_pc       <= 32'h0;
    end else begin
      state_q       <= state_d;
      trap_taken    <= take_trap;
      mret_redirect <= take_mret;
      if (take_trap) begin
        mepc_q   <= exception_pc & ALIGN_MASK;
        mcause_q <= {28'h0, exception_code};
        mtval_q  <= exception_val;
        mpie_q   <= mie_q;
        mie_q    <= 1'b0;
      end else if (take_mret) begin
        mret_pc <= mepc_q;
        mie_q   <= mpie_q;
        mpie_q  <= 1'b1;
      end else if (do_csr_wr) begin
        case (csr_addr)
          ADDR_MSTATUS: begin
            mie_q  <= csr_wval[3];
            mpie_q <= csr_wval[7];
          end
          ADDR_MTVEC:    mtvec_q    <= csr_wval & ALIGN_MASK;
          ADDR_MSCRATCH: mscratch_q <= csr_wval;
          ADDR_MEPC:     mepc_q     <= csr_wval & ALIGN_MASK;
          ADDR_MCAUSE:   mcause_q   <= csr_wval;
          ADDR_MTVAL:    mtval_q    <= csr_wval;
          default:       ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_csr_trap_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        exception_valid;
  logic [3:0]  exception_code;
  logic [31:0] exception_pc;
  logic [31:0] exception_val;
  logic [31:0] trap_vector;
  logic        trap_taken;
  logic        csr_en;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        mret_valid;
  logic        mret_redirect;
  logic [31:0] mret_pc;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] rv;

  csr_trap_unit dut (
    .clk(clk), .rst(rst),
    .exception_valid(exception_valid), .exception_code(exception_code),
    .exception_pc(exception_pc), .exception_val(exception_val),
    .trap_vector(trap_vector), .trap_taken(trap_taken),
    .csr_en(csr_en), .csr_op(csr_op), .csr_addr(csr_addr),
    .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .mret_valid(mret_valid), .mret_redirect(mret_redirect), .mret_pc(mret_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_en   = 1'b1;
    csr_op   = 2'b00;
    csr_addr = a;
    #1;
    d      = csr_rdata;
    csr_en = 1'b0;
  endtask

  task automatic csr_do(input logic [1:0] op, input logic [11:0] a, input logic [31:0] w);
    csr_en    = 1'b1;
    csr_op    = op;
    csr_addr  = a;
    csr_wdata = w;
    tick();
    csr_en = 1'b0;
    csr_op = 2'b00;
  endtask

  task automatic check_reg(input string tag, input logic [11:0] a, input logic [31:0] val);
    expect_val(tag, val);
    rd(a, rv);
    check(rv);
  endtask

  initial begin
    rst = 1'b1;
    exception_valid = 1'b0; exception_code = 4'h0;
    exception_pc = 32'h0; exception_val = 32'h0;
    csr_en = 1'b0; csr_op = 2'b00; csr_addr = 12'h0; csr_wdata = 32'h0;
    mret_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    expect_val("rst_trap_taken", 32'h0);    check({31'h0, trap_taken});
    expect_val("rst_mret_redirect", 32'h0); check({31'h0, mret_redirect});
    expect_val("rst_trap_vector", 32'h8000_0000); check(trap_vector);
    check_reg("rst_mstatus", 12'h300, 32'h0000_1800);
    check_reg("rst_mtvec", 12'h305, 32'h8000_0000);
    check_reg("misa", 12'h301, 32'h4000_0100);

    // Trap entry
    csr_do(2'b10, 12'h300, 32'h8);
    check_reg("mstatus_mie_set", 12'h300, 32'h0000_1808);
    exception_valid = 1'b1; exception_code = 4'd2;
    exception_pc = 32'h8000_0106; exception_val = 32'hFFFF_FFFF;
    expect_val("trap_vector_pre_trap", 32'h8000_0000); #1; check(trap_vector);
    tick();
    exception_valid = 1'b0;
    expect_val("trap_taken_pulse", 32'h1); check({31'h0, trap_taken});
    check_reg("trap_mepc", 12'h341, 32'h8000_0104);
    check_reg("trap_mcause", 12'h342, 32'h2);
    check_reg("trap_mtval", 12'h343, 32'hFFFF_FFFF);
    check_reg("trap_mstatus", 12'h300, 32'h0000_1880);
    tick();
    expect_val("trap_taken_fall", 32'h0); check({31'h0, trap_taken});

    // mret
    mret_valid = 1'b1;
    tick();
    mret_valid = 1'b0;
    expect_val("mret_redirect_pulse", 32'h1); check({31'h0, mret_redirect});
    expect_val("mret_pc", 32'h8000_0104); check(mret_pc);
    check_reg("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();
    expect_val("mret_redirect_fall", 32'h0); check({31'h0, mret_redirect});
    expect_val("mret_pc_held", 32'h8000_0104); check(mret_pc);

    // CSR ops and masking
    csr_do(2'b01, 12'h305, 32'h8000_1003);
    check_reg("mtvec_masked", 12'h305, 32'h8000_1000);
    expect_val("trap_vector_new", 32'h8000_1000); check(trap_vector);
    csr_do(2'b01, 12'h340, 32'h0000_00FF);
    csr_do(2'b11, 12'h340, 32'h0000_000F);
    check_reg("mscratch_rc", 12'h340, 32'h0000_00F0);
    csr_do(2'b01, 12'h341, 32'h1234_5677);
    check_reg("mepc_masked", 12'h341, 32'h1234_5674);
    csr_do(2'b01, 12'h300, 32'hFFFF_FFF7);
    check_reg("mstatus_masked", 12'h300, 32'h0000_1880);
    csr_do(2'b01, 12'h300, 32'h0000_0088);
    csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'hF14; csr_wdata = 32'hDEAD_BEEF;
    #1;
    expect_val("illegal_mhartid_write", 32'h1); check({31'h0, csr_illegal});
    tick();
    csr_en = 1'b0; csr_op = 2'b00;
    check_reg("mhartid_unchanged", 12'hF14, 32'h0);
    csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h7C0; csr_wdata = 32'h1;
    #1;
    expect_val("illegal_unmapped", 32'h1); check({31'h0, csr_illegal});
    expect_val("unmapped_rdata", 32'h0); check(csr_rdata);
    tick();
    csr_en = 1'b0; csr_op = 2'b00;
    csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h0;
    #1;
    expect_val("legal_mscratch_access", 32'h0); check({31'h0, csr_illegal});
    csr_en = 1'b0; csr_op = 2'b00;

    // Collision: exception + mret + CSR write
    exception_valid = 1'b1; exception_code = 4'd2;
    exception_pc = 32'h8000_0200; exception_val = 32'h0000_0055;
    mret_valid = 1'b1;
    csr_en = 1'b1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'h0000_1234;
    tick();
    mret_valid = 1'b0;
    expect_val("coll_trap_taken", 32'h1); check({31'h0, trap_taken});
    expect_val("coll_mret_redirect", 32'h0); check({31'h0, mret_redirect});
    expect_val("coll_mret_pc", 32'h8000_0104); check(mret_pc);
    // TRAP_ACK cycle: second exception and CSR write must be dropped
    exception_code = 4'd5; exception_pc = 32'h8000_0400; exception_val = 32'h66;
    csr_wdata = 32'h0000_AAAA;
    tick();
    exception_valid = 1'b0;
    csr_en = 1'b0; csr_op = 2'b00;
    expect_val("ack_trap_taken_fall", 32'h0); check({31'h0, trap_taken});
    check_reg("coll_mscratch", 12'h340, 32'h0000_00F0);
    check_reg("coll_mcause", 12'h342, 32'h2);
    check_reg("coll_mepc", 12'h341, 32'h8000_0200);
    check_reg("coll_mtval", 12'h343, 32'h0000_0055);
    check_reg("coll_mstatus", 12'h300, 32'h0000_1880);

    // Reset mid-trap
    exception_valid = 1'b1; exception_code = 4'd7;
    exception_pc = 32'h8000_0300; exception_val = 32'h77;
    tick();
    exception_valid = 1'b0;
    expect_val("pre_rst_trap_taken", 32'h1); check({31'h0, trap_taken});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_val("midrst_trap_taken", 32'h0); check({31'h0, trap_taken});
    expect_val("midrst_mret_pc", 32'h0); check(mret_pc);
    expect_val("midrst_trap_vector", 32'h8000_0000); check(trap_vector);
    check_reg("midrst_mstatus", 12'h300, 32'h0000_1800);
    check_reg("midrst_mepc", 12'h341, 32'h0);
    check_reg("midrst_mcause", 12'h342, 32'h0);
    check_reg("midrst_mtval", 12'h343, 32'h0);
    check_reg("midrst_mscratch", 12'h340, 32'h0);
    // FSM back in IDLE: a fresh exception is accepted immediately
    exception_valid = 1'b1; exception_code = 4'd3; exception_pc = 32'h8000_0010;
    tick();
    exception_valid = 1'b0;
    expect_val("post_rst_trap_taken", 32'h1); check({31'h0, trap_taken});
    check_reg("post_rst_mcause", 12'h342, 32'h3);

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
